// File: rtl/upcount.sv
// upcount: WIDTH-bit up-counter with synchronous active-low reset,
// parallel load, and a terminal-count flag decoded from the count.
module upcount #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Count register: reset beats load, load beats count; wraps modulo 2^WIDTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= data_in;
        end else begin
            q <= q + ONE;
        end
    end

    // Terminal count: high only while the registered count is all ones.
    assign tc = &q;

endmodule

// File: tb/tb_upcount.sv
// tb_upcount: directed scenarios plus randomized traffic against an
// arithmetic reference model of the counter.
module tb_upcount;

    localparam int unsigned WIDTH = 4;
    localparam int          MODULUS = 1 << WIDTH;

    logic             clk;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] q;
    logic             tc;

    int n_checks = 0;
    int n_fail   = 0;
    int mq       = 0;   // reference count

    upcount #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .data_in (data_in),
        .q       (q),
        .tc      (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; 4-state compare so X/Z on q is caught.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive inputs (called at negedge), take one rising edge, update the model, then check.
    task automatic tick(input logic r, input logic l, input logic [WIDTH-1:0] d, input string tag);
        rst     = r;
        load    = l;
        data_in = d;
        @(posedge clk);
        if (r == 1'b0)      mq = 0;
        else if (l == 1'b1) mq = int'(d);
        else                mq = (mq + 1) % MODULUS;
        #1;
        check({tag, "_q"},  32'(q),  32'(mq));
        check({tag, "_tc"}, 32'(tc), (mq == MODULUS - 1) ? 32'd1 : 32'd0);
        @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        load    = 1'b0;
        data_in = '0;
        @(negedge clk);

        // Reset with a coincident load.
        tick(1'b0, 1'b1, 4'b1010, "reset");

        // First edge after reset counts normally.
        tick(1'b1, 1'b0, 4'b0000, "first_count");
        check("first_count_is_1", 32'(q), 32'd1);

        // Load then count.
        tick(1'b1, 1'b1, 4'b0011, "load3");
        tick(1'b1, 1'b0, 4'b0011, "cnt4");
        tick(1'b1, 1'b0, 4'b0011, "cnt5");
        tick(1'b1, 1'b0, 4'b0011, "cnt6");
        check("cnt6_abs", 32'(q), 32'd6);

        // Wrap and terminal count.
        tick(1'b1, 1'b1, 4'b1101, "load13");
        tick(1'b1, 1'b0, 4'b0000, "cnt14");
        tick(1'b1, 1'b0, 4'b0000, "cnt15");
        check("tc_at_15", 32'(tc), 32'd1);
        tick(1'b1, 1'b0, 4'b0000, "wrap0");
        check("wrap_abs", 32'(q), 32'd0);
        tick(1'b1, 1'b0, 4'b0000, "cnt1");

        // Data changes without load do not disturb counting; then load takes it.
        tick(1'b1, 1'b0, 4'b1000, "data_noload");
        tick(1'b1, 1'b1, 4'b1000, "load8");
        check("load8_abs", 32'(q), 32'd8);

        // Between edges, input changes have no effect.
        load    = 1'b1;
        data_in = 4'b0101;
        #2;
        check("hold_between_edges", 32'(q), 32'd8);
        load = 1'b0;

        // X on data_in without a load is harmless.
        tick(1'b1, 1'b0, 4'bxxxx, "x_noload");

        // Reset priority and synchronicity: count to 6, then drop rst mid-cycle.
        tick(1'b1, 1'b1, 4'b0110, "load6");
        rst = 1'b0;
        #2;
        check("rst_async_hold", 32'(q), 32'd6);
        tick(1'b0, 1'b0, 4'b0000, "rst_midcount");
        tick(1'b1, 1'b0, 4'b0000, "post_rst");
        tick(1'b0, 1'b1, 4'b1111, "rst_over_load");

        // Continuous load of all ones, then wrap.
        tick(1'b1, 1'b1, 4'b1111, "hold15_a");
        tick(1'b1, 1'b1, 4'b1111, "hold15_b");
        tick(1'b1, 1'b1, 4'b1111, "hold15_c");
        check("hold15_tc", 32'(tc), 32'd1);
        tick(1'b1, 1'b0, 4'b1111, "after_hold");
        check("after_hold_abs", 32'(q), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            logic             r;
            logic             l;
            logic [WIDTH-1:0] d;
            r = ($urandom_range(15) != 0);
            l = ($urandom_range(3) == 0);
            d = WIDTH'($urandom);
            tick(r, l, d, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/upcount.md
UPCOUNT -- requirements
Module: upcount

Interface
REQ-001 Parameter: WIDTH, default 4, counter and data bit width; all widths below are WIDTH, and values and scenarios use WIDTH=4.
REQ-002 Port: clk  input  1  single clock; all state changes occur on its rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-low (0 = reset, sampled only on rising clk).
REQ-004 Port: load  input  1  parallel-load request, sampled on rising clk.
REQ-005 Port: data_in  input  WIDTH  parallel-load value, sampled on rising clk when load=1.
REQ-006 Port: q  output  WIDTH  current count; registered output, no combinational path from any input.
REQ-007 Port: tc  output  1  terminal count; 1 when q equals all ones, else 0; decoded combinationally from q only.

Function
REQ-008 Per rising clk, the block SHALL apply exactly one action, in strict priority: reset, then load, then count.
REQ-009 Reset: rst=0 at the edge SHALL set q to 0, regardless of load and data_in.
REQ-010 Load: rst=1 and load=1 SHALL set q to data_in, with one-cycle latency (new value visible after that edge).
REQ-011 Count: rst=1 and load=0 SHALL set q to q+1; there is no enable, so the counter advances on every such edge.
REQ-012 Arithmetic SHALL be unsigned modulo 2^WIDTH: all ones + 1 wraps to 0 with no sticky flag, stall or saturation.
REQ-013 Loading all ones SHALL be legal; the next count edge wraps q to 0.
REQ-014 Between rising edges, q SHALL hold its value; changes on load and data_in between edges SHALL have no effect.
REQ-015 tc SHALL track q in the same cycle: 1 only while q is all ones (15 for WIDTH=4).
REQ-016 A reset asserted mid-count or coincident with load SHALL win; q is 0 after that edge.
REQ-017 The first rising edge with rst=1 after reset SHALL act normally: load if load=1, otherwise q becomes 1.
REQ-018 X or Z on data_in SHALL only affect q on an edge where a load actually occurs.

Reset
REQ-019 Reset SHALL be synchronous: asserting rst without a rising clk SHALL not change q.
REQ-020 After any edge with rst=0: q=0 and tc=0.
REQ-021 Before the first reset edge, q is undefined, and benches SHALL apply reset before checking outputs.
REQ-022 Reset SHALL be held for at least one rising edge, with no other initialisation required.

Verification
REQ-023 Reset: rst=0 for 1 edge with load=1, data_in=1010 -> q=0000, tc=0.
REQ-024 Load then count: rst=1, load=1, data_in=0011 for 1 edge -> q=0011; then load=0 for 3 edges -> q=0100, 0101, 0110.
REQ-025 Wrap and tc: load 1101, then count 4 edges -> q=1110, 1111 (tc=1), 0000 (tc=0), 0001.
REQ-026 Load priority and data stability: while counting, data_in changes to 1000 with load=0 -> count is unaffected; then load=1 with data_in=1000 -> q=1000 on the next edge.
REQ-027 Reset priority and synchronicity: counting at q=0110, pull rst=0 mid-cycle -> q unchanged until the edge, then 0000; rst=0 with load=1 also gives 0000.
REQ-028 Continuous load: load=1 held with data_in=1111 for 3 edges -> q stays 1111, tc stays 1; load=0 -> next edge q=0000.
